exp_share_arb: RTL and testbench
================================

Name: exp_share_arb

Overview:
- Shares one pipelined exp unit (exp_mult_0-based, fixed latency) among NUM_REQ requesters, e.g. the per-head softmax lanes.
- Round-robin arbitration with a valid/ready handshake per requester.
- Tags each issued operand and routes the exp result back to the issuing requester as a one-hot registered response.
- Sits between the attention score lanes and a single exp instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IN_DATA_WIDTH, 32, operand width into the exp unit.
- OUT_DATA_WIDTH, 16, exp result width.
- EXP_LATENCY, 1, cycles from exp enable to exp valid/data (1..4).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester operand valid.
- o_req_ready  output  NUM_REQ  per-requester ready; at most one bit set.
- i_req_data  input  NUM_REQ*IN_DATA_WIDTH  packed operands; requester k at bits [k*IN_DATA_WIDTH +: IN_DATA_WIDTH].
- o_exp_en  output  1  enable to the exp unit.
- o_exp_data  output  IN_DATA_WIDTH  operand to the exp unit.
- i_exp_valid  input  1  exp unit result valid.
- i_exp_data  input  OUT_DATA_WIDTH  exp unit result.
- o_rsp_valid  output  NUM_REQ  one-hot response valid, one cycle.
- o_rsp_data  output  OUT_DATA_WIDTH  response data, shared by all requesters.
- o_busy  output  1  high while any operation is in flight.
- o_err  output  1  sticky flag: exp valid arrived with no matching tag.

Behaviour:
- Reset (async, rst_n low): rr pointer=0, tag pipeline cleared, o_rsp_valid=0, o_rsp_data=0, o_err=0, o_busy=0. Reset mid-operation discards all in-flight results; no response is ever issued for them.
- Arbitration (combinational):
  - Grant = first requester with i_req_valid, searching from the pointer upward, modulo NUM_REQ.
  - o_req_ready = one-hot of the grant, or 0 if no requester is valid.
  - Accept = i_req_valid & o_req_ready. The arbiter never stalls, so at most one accept per cycle, back-to-back allowed.
- Issue (combinational):
  - o_exp_en = accept.
  - o_exp_data = granted requester's operand; 0 when idle.
- Pointer: on accept, pointer <= (grant+1) mod NUM_REQ. Unchanged when idle.
- Tag pipeline:
  - EXP_LATENCY-deep shift register of {valid, index}, shifted every cycle.
  - Stage 0 is loaded with {accept, grant}.
  - The tail stage is aligned with i_exp_valid.
- Response (registered):
  - If i_exp_valid and tail tag valid: o_rsp_valid <= onehot(tail index), o_rsp_data <= i_exp_data.
  - Otherwise o_rsp_valid <= 0 and o_rsp_data holds its value.
- Latency: accept in cycle T, response in cycle T+EXP_LATENCY+1.
- Mismatch: i_exp_valid=1 with tail tag invalid -> drop data, o_err <= 1 (sticky until reset). Tail tag valid with i_exp_valid=0 -> tag dropped, o_err <= 1.
- o_busy: OR of all tag-stage valid bits and o_rsp_valid.
- Requesters hold valid/data until accepted; data change while valid and not ready is permitted (no protocol check).

Optional Feature:
- Macro EXP_ARB_PRIO_EN.
- Defined: requester 0 has fixed top priority. It is granted whenever i_req_valid[0]=1. The remaining requesters are round-robin among themselves, and the pointer only advances on grants to requesters 1..NUM_REQ-1.
- Undefined: pure round-robin across all requesters as described above.

Test Plan:
- Single request: req2 valid with 0x00000400, EXP_LATENCY=1 -> o_req_ready=4'b0100 same cycle; o_exp_en=1, o_exp_data=0x400; o_rsp_valid=4'b0100 two cycles later with the data from i_exp_data.
- All four requesters valid continuously from reset -> grants 0,1,2,3,0,1 on consecutive cycles; responses arrive in the same order, each exactly 2 cycles after its grant.
- Sparse: req1 and req3 valid, pointer=2 -> grant 3 then 1; pointer ends at 2.
- Reset mid-flight: accept req0, assert rst_n=0 for 1 cycle before the response -> no o_rsp_valid after reset release, o_busy=0, o_err=0.
- Spurious valid: drive i_exp_valid=1 with no prior accept -> o_rsp_valid stays 0, o_err=1 and stays 1 until reset.
- EXP_ARB_PRIO_EN defined: req0 and req1 both held valid -> req0 granted every cycle; req1 is granted only after req0 deasserts.

Source files
------------

// File: rtl/exp_share_arb.sv
// exp_share_arb
// Shares one pipelined exp unit among NUM_REQ requesters (e.g. per-head
// softmax lanes). Requesters are granted round-robin through a valid/ready
// handshake. Every issued operand carries a tag down a shift register that
// matches the exp unit latency. The returning result is routed back to the
// issuing requester as a registered one-hot response.
//
// Optional feature (macro EXP_ARB_PRIO_EN):
//   When defined, requester 0 has fixed top priority. Requesters
//   1..NUM_REQ-1 rotate among themselves, and the pointer only moves on
//   their grants. When undefined, all requesters are pure round-robin.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_req_valid  per-requester operand valid
//   o_req_ready  per-requester ready (one-hot grant, or zero)
//   i_req_data   packed operands, requester k at [k*IN_DATA_WIDTH +: IN_DATA_WIDTH]
//   o_exp_en     enable to the exp unit (one accept this cycle)
//   o_exp_data   operand to the exp unit, zero when idle
//   i_exp_valid  exp unit result valid
//   i_exp_data   exp unit result
//   o_rsp_valid  one-hot response valid, one cycle
//   o_rsp_data   response data shared by all requesters
//   o_busy       any tag in flight or response being presented
//   o_err        sticky: exp valid and tail tag disagreed
module exp_share_arb #(
  parameter int NUM_REQ        = 4,
  parameter int IN_DATA_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int EXP_LATENCY    = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  output logic [NUM_REQ-1:0]                o_req_ready,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0]  i_req_data,
  output logic                              o_exp_en,
  output logic [IN_DATA_WIDTH-1:0]          o_exp_data,
  input  logic                              i_exp_valid,
  input  logic [OUT_DATA_WIDTH-1:0]         i_exp_data,
  output logic [NUM_REQ-1:0]                o_rsp_valid,
  output logic [OUT_DATA_WIDTH-1:0]         o_rsp_data,
  output logic                              o_busy,
  output logic                              o_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

`ifdef EXP_ARB_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic                      grant_found;
  logic [IDX_W-1:0]          grant_idx;
  int                        cand_int;
  logic [IDX_W-1:0]          cand_idx;
  logic                      accept;

  logic [EXP_LATENCY-1:0]    tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]          tag_idx_q [EXP_LATENCY];
  logic [IDX_W-1:0]          tag_idx_d [EXP_LATENCY];
  logic                      tail_vld;
  logic [IDX_W-1:0]          tail_idx;

  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [OUT_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                      err_q, err_d;

  // Grant search: walk upward from the pointer with wrap-around and take the
  // first valid requester. In priority mode requester 0 wins outright, and
  // it is skipped by the rotating search so it never consumes a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_int    = 0;
    cand_idx    = '0;
    if (PRIO_EN && i_req_valid[0]) begin
      grant_found = 1'b1;
      grant_idx   = '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand_int = int'(ptr_q) + i;
        if (cand_int >= NUM_REQ) begin
          cand_int = cand_int - NUM_REQ;
        end
        cand_idx = IDX_W'(cand_int);
        if (!grant_found && i_req_valid[cand_idx] &&
            !(PRIO_EN && (cand_idx == '0))) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  // The arbiter never stalls, so a grant is always an accept.
  assign accept = grant_found;

  always_comb begin
    o_req_ready = '0;
    o_exp_data  = '0;
    if (grant_found) begin
      o_req_ready[grant_idx] = 1'b1;
      o_exp_data = i_req_data[int'(grant_idx)*IN_DATA_WIDTH +: IN_DATA_WIDTH];
    end
  end

  assign o_exp_en = accept;

  // Pointer moves to one past the winner. Priority grants to requester 0
  // leave it untouched so the others keep their place in the rotation.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && !(PRIO_EN && (grant_idx == '0))) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Tag shift register. It runs every cycle so the tail stays aligned with
  // the fixed-latency exp result.
  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = accept;
    for (int s = 0; s < EXP_LATENCY; s++) begin
      tag_idx_d[s] = '0;
    end
    tag_idx_d[0] = grant_idx;
    for (int s = 1; s < EXP_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  assign tail_vld = tag_vld_q[EXP_LATENCY-1];
  assign tail_idx = tag_idx_q[EXP_LATENCY-1];

  // A response goes out only when result and tag agree. Any disagreement
  // drops the orphan and latches the sticky error flag.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q | (i_exp_valid ^ tail_vld);
    if (i_exp_valid && tail_vld) begin
      rsp_valid_d[tail_idx] = 1'b1;
      rsp_data_d            = i_exp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      for (int s = 0; s < EXP_LATENCY; s++) begin
        tag_idx_q[s] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      tag_vld_q   <= tag_vld_d;
      for (int s = 0; s < EXP_LATENCY; s++) begin
        tag_idx_q[s] <= tag_idx_d[s];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_err       = err_q;
  assign o_busy      = (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_exp_share_arb.sv
// tb_exp_share_arb
// Self-checking bench for exp_share_arb with default parameters.
// A small exp-unit model feeds results back after EXP_LATENCY cycles.
// Accepted operands push their expected response onto a queue. A
// negedge monitor pops and compares each response when it falls due.
module tb_exp_share_arb;

  localparam int NUM_REQ = 4;
  localparam int IW      = 32;
  localparam int OW      = 16;
  localparam int LAT     = 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     i_req_valid;
  logic [NUM_REQ-1:0]     o_req_ready;
  logic [NUM_REQ*IW-1:0]  i_req_data;
  logic                   o_exp_en;
  logic [IW-1:0]          o_exp_data;
  logic                   i_exp_valid;
  logic [OW-1:0]          i_exp_data;
  logic [NUM_REQ-1:0]     o_rsp_valid;
  logic [OW-1:0]          o_rsp_data;
  logic                   o_busy;
  logic                   o_err;

  int  checks = 0;
  int  errors = 0;
  int  cycle  = 0;
  logic mon_en    = 1'b0;
  logic force_exp = 1'b0;
  logic drop_exp  = 1'b0;

  typedef struct {
    logic [NUM_REQ-1:0] onehot;
    logic [OW-1:0]      data;
    int                 due;
  } rsp_t;
  rsp_t sb_q[$];
  rsp_t mon_e;

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] exp_ready;
  } vec_t;

  exp_share_arb #(
    .NUM_REQ(NUM_REQ), .IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW), .EXP_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_data(i_req_data),
    .o_exp_en(o_exp_en), .o_exp_data(o_exp_data),
    .i_exp_valid(i_exp_valid), .i_exp_data(i_exp_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [OW-1:0] exp_fn(input logic [IW-1:0] x);
    return x[15:0] ^ x[31:16] ^ 16'h5A5A;
  endfunction

  function automatic logic [IW-1:0] lane_data(input int e, input int k);
    return 32'h0000_0400 + (32'(k) << 24) + (32'(e) << 16);
  endfunction

  // Exp unit model: fixed latency, cleared by the shared reset.
  logic [LAT-1:0] pipe_vld;
  logic [OW-1:0]  pipe_dat [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int s = 0; s < LAT; s++) pipe_dat[s] <= '0;
    end else begin
      pipe_vld[0] <= o_exp_en;
      pipe_dat[0] <= exp_fn(o_exp_data);
      for (int s = 1; s < LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_dat[s] <= pipe_dat[s-1];
      end
    end
  end
  assign i_exp_valid = (pipe_vld[LAT-1] & ~drop_exp) | force_exp;
  assign i_exp_data  = pipe_dat[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cycle, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input int e);
    i_req_valid = valid;
    for (int k = 0; k < NUM_REQ; k++) i_req_data[k*IW +: IW] = lane_data(e, k);
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] oh);
    int r = 0;
    for (int k = 0; k < NUM_REQ; k++) if (oh[k]) r = k;
    return r;
  endfunction

  // Applied at posedge+1; checks issue at negedge and records the response.
  task automatic issueCycle(input logic [NUM_REQ-1:0] valid, input int e,
                            input logic [NUM_REQ-1:0] exp_ready, input string tag);
    int gi;
    logic acc;
    applyStimulus(valid, e);
    @(negedge clk);
    acc = |exp_ready;
    gi  = onehot_idx(exp_ready);
    checkOutput({tag, "_ready"}, 32'(o_req_ready), 32'(exp_ready));
    checkOutput({tag, "_exp_en"}, 32'(o_exp_en), 32'(acc));
    checkOutput({tag, "_exp_data"}, o_exp_data, acc ? lane_data(e, gi) : 32'h0);
    if (acc) sb_q.push_back('{exp_ready, exp_fn(lane_data(e, gi)), cycle + LAT + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drainScoreboard();
    int n = 0;
    i_req_valid = '0;
    while (sb_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Response monitor: either the due response or silence every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].due <= cycle) begin
        mon_e = sb_q.pop_front();
        checkOutput("rsp_valid", 32'(o_rsp_valid), 32'(mon_e.onehot));
        checkOutput("rsp_data", 32'(o_rsp_data), 32'(mon_e.data));
      end else begin
        checkOutput("rsp_idle", 32'(o_rsp_valid), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
`ifndef EXP_ARB_PRIO_EN
    vec_t vecs[15];
    logic [NUM_REQ-1:0] rr_seq [6];
`endif
    rst_n       = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(o_rsp_valid), 32'h0);
    checkOutput("reset_rsp_data", 32'(o_rsp_data), 32'h0);
    checkOutput("reset_err", 32'(o_err), 32'h0);
    checkOutput("reset_busy", 32'(o_busy), 32'h0);
    checkOutput("reset_exp_en", 32'(o_exp_en), 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

`ifndef EXP_ARB_PRIO_EN
    // Pointer trace in comments: value before each vector.
    vecs[0]  = '{4'b0100, 4'b0100};  // p0 single req2 -> p3
    vecs[1]  = '{4'b0000, 4'b0000};  // p3 idle
    vecs[2]  = '{4'b1111, 4'b1000};  // p3 -> p0
    vecs[3]  = '{4'b1111, 4'b0001};  // p0 -> p1
    vecs[4]  = '{4'b1111, 4'b0010};  // p1 -> p2
    vecs[5]  = '{4'b1010, 4'b1000};  // p2 sparse: 3 first -> p0
    vecs[6]  = '{4'b0010, 4'b0010};  // p0 then 1 -> p2
    vecs[7]  = '{4'b1111, 4'b0100};  // p2 confirms pointer -> p3
    vecs[8]  = '{4'b1001, 4'b1000};  // p3 -> p0
    vecs[9]  = '{4'b1001, 4'b0001};  // p0 -> p1
    vecs[10] = '{4'b0000, 4'b0000};  // p1 idle keeps pointer
    vecs[11] = '{4'b0101, 4'b0100};  // p1 -> p3
    vecs[12] = '{4'b0011, 4'b0001};  // p3 wraps to 0 -> p1
    vecs[13] = '{4'b0001, 4'b0001};  // p1 only 0 valid
    vecs[14] = '{4'b0000, 4'b0000};
    for (int e = 0; e < 15; e++) issueCycle(vecs[e].valid, e, vecs[e].exp_ready, "vec");
    drainScoreboard();

    // All requesters valid continuously from reset.
    doReset();
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int j = 0; j < 6; j++) issueCycle(4'b1111, 100 + j, rr_seq[j], "rr");
    i_req_valid = '0;
    @(negedge clk);
    checkOutput("busy_in_flight", 32'(o_busy), 32'h1);
    @(posedge clk);
    #1;
    drainScoreboard();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("busy_idle", 32'(o_busy), 32'h0);
    @(posedge clk);
    #1;
`else
    // Requester 0 dominates while held; 1 gets in once 0 drops.
    doReset();
    for (int j = 0; j < 4; j++) issueCycle(4'b0011, 200 + j, 4'b0001, "prio");
    issueCycle(4'b0010, 210, 4'b0010, "prio_r1");
    issueCycle(4'b1110, 211, 4'b0100, "prio_rr");
    issueCycle(4'b1111, 212, 4'b0001, "prio_again");
    drainScoreboard();
`endif

    // Reset while a result is in flight: nothing may emerge afterwards.
    doReset();
    issueCycle(4'b0001, 300, 4'b0001, "midrst");
    sb_q.delete();
    i_req_valid = '0;
    doReset();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checkOutput("midrst_busy", 32'(o_busy), 32'h0);
      checkOutput("midrst_err", 32'(o_err), 32'h0);
    end
    @(posedge clk);
    #1;

    // Spurious exp valid with no tag: sticky error, no response.
    force_exp = 1'b1;
    @(posedge clk);
    #1;
    force_exp = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checkOutput("spurious_err", 32'(o_err), 32'h1);
    end
    @(posedge clk);
    #1;
    doReset();
    @(negedge clk);
    checkOutput("err_cleared", 32'(o_err), 32'h0);
    @(posedge clk);
    #1;

    // Tag arrives at the tail with no exp valid: dropped, error latched.
    drop_exp = 1'b1;
    issueCycle(4'b0010, 400, 4'b0010, "droptag");
    sb_q.delete();
    i_req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("droptag_err", 32'(o_err), 32'h1);
    @(posedge clk);
    #1;
    drop_exp = 1'b0;
    doReset();
    repeat (2) @(posedge clk);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
